alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Round-robin scheduler that shares one simplealu instance between NREQ requesters.
- Accepts one operation at a time, pulses the ALU start, waits for done and returns the 16-bit result to the granted requester over a valid/ready response.
- Guards against a stuck ALU with a done timeout.
- Sits between client blocks and the ALU's alu_if signals in the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, max cycles in WAIT before an error response (≥4).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept pulse.
- req_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i].
- req_b  in  8*NREQ  operand B, same packing.
- req_op  in  2*NREQ  op_t from simplealu_pkg (ADD=0, SUB=1, XOR=2, MUL=3).
- rsp_valid  out  NREQ  one-hot response valid.
- rsp_ready  in  NREQ  per-requester response ready.
- rsp_result  out  16  result for the current response.
- rsp_err  out  1  1 = ALU timeout; rsp_result is 0 in that case.
- alu_start  out  1  ALU start pulse.
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_op  out  2  ALU operation.
- alu_result  in  16  ALU result.
- alu_done  in  1  ALU done.
- busy  out  1  high in any state other than IDLE.
- ops_count  out  16  count of completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset: state=IDLE; last_grant=NREQ-1, so requester 0 has top priority.
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, alu_start=0, alu_a=0, alu_b=0, alu_op=0, busy=0, ops_count=0, wait counter=0.
- Reset mid-operation: aborts immediately and no response is issued. Any alu_done arriving afterwards is ignored.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, choose winner g = first set bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - Assert req_ready[g] combinationally this cycle.
  - Register operands and op into alu_a/alu_b/alu_op and g into grant. Next state = ISSUE.
  - No request: stay.
- ISSUE:
  - alu_start=1 for exactly this one cycle; alu_a/b/op stay stable from ISSUE until the next accept.
  - Clear the wait counter. Next state = WAIT.
- WAIT:
  - The ALU asserts alu_done 2 cycles after the start cycle.
  - On alu_done=1: capture alu_result into rsp_result, rsp_err=0, next state = RESP.
  - Otherwise increment the counter. When counter == TIMEOUT-1 with no done: rsp_result=0, rsp_err=1, next state = RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_result and rsp_err are held stable.
  - On rsp_ready[grant]=1: last_grant=grant, ops_count++, rsp_valid clears, next state = IDLE.
  - rsp_ready on other indices is ignored.
- alu_done seen outside WAIT is ignored and does not affect state.
- Only one operation is in flight; req_ready stays 0 outside IDLE.
- req_valid may drop without acceptance, with no effect. Once req_valid is asserted, the requester holds it until req_ready.
- Latency, with accept in cycle t: alu_start in t+1, alu_done in t+3, rsp_valid from t+4. Best-case throughput is one op per 5 cycles.
- Arithmetic is done entirely by the ALU.
- Expected results: SUB borrow wraps into 16 bits; MUL is the full 16-bit product.
- A requester with rsp_valid pending may assert a new req_valid. It is arbitrated after the handshake completes.

Test Plan:
- Single ADD: requester 0 sends a=200, b=100, op=ADD; rsp_ready held 1 -> req_ready[0] in cycle t, alu_start in t+1, rsp_valid[0] in t+4, rsp_result=0x012C, rsp_err=0, ops_count=1.
- Op coverage, requester 2:
  - MUL 255×255 -> 0xFE01.
  - SUB 5-10 -> 0xFFFB.
  - XOR 0xA5^0x0F -> 0x00AA.
- Fairness: all four req_valid held continuously with immediate rsp_ready -> grant order 0,1,2,3,0,1; no requester gets two consecutive grants while others wait.
- Backpressure: rsp_ready[1] low for 10 cycles -> rsp_valid[1] and rsp_result stay constant, req_ready=0 throughout. Raising rsp_ready gives completion in that cycle and IDLE next.
- Timeout: ALU model never asserts done, TIMEOUT=16 -> rsp_valid with rsp_err=1 and rsp_result=0 exactly 16 cycles after entering WAIT.
- Reset in WAIT: reset asserted 1 cycle after alu_start -> all outputs return to reset values next cycle. The late alu_done is ignored, no rsp_valid appears, and requester 0 is granted first afterwards.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one simplealu between NREQ requesters.
// One operation is in flight at a time; a stuck ALU is cut off by a done timeout.
module alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [15:0]       rsp_result,
  output logic              rsp_err,
  output logic              alu_start,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [1:0]        alu_op,
  input  logic [15:0]       alu_result,
  input  logic              alu_done,
  output logic              busy,
  output logic [15:0]       ops_count
);

  localparam int            GW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int            CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, last_grant, winner, rr_idx;
  logic          any_req;
  logic [CW-1:0] wait_cnt;
  logic          timed_out, rsp_done;

  // Winner is the first valid requester after last_grant, wrapping modulo NREQ.
  always_comb begin
    winner  = last_grant;
    any_req = 1'b0;
    rr_idx  = last_grant;
    for (int i = 1; i <= NREQ; i++) begin
      rr_idx = GW'((int'(last_grant) + i) % NREQ);
      if (!any_req && req_valid[rr_idx]) begin
        winner  = rr_idx;
        any_req = 1'b1;
      end
    end
  end

  assign timed_out = (state == WAIT) && !alu_done && (wait_cnt == WAIT_LAST);
  assign rsp_done  = (state == RESP) && rsp_ready[grant];

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_done || timed_out) state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // An accept pulse during reset would be discarded by the flops, so mask it.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    alu_start = (state == ISSUE);
    busy      = (state != IDLE);
    if (state == IDLE && any_req && !reset) req_ready = NREQ'(1) << winner;
    if (state == RESP)                      rsp_valid = NREQ'(1) << grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= LAST_INIT;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      wait_cnt   <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      ops_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= winner;
            alu_a  <= req_a[{winner, 3'b000} +: 8];
            alu_b  <= req_b[{winner, 3'b000} +: 8];
            alu_op <= req_op[{winner, 1'b0} +: 2];
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end else if (timed_out) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            last_grant <= grant;
            ops_count  <= ops_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
